// File: rtl/gpio_input_port.sv
// gpio_input_port: 8-bit memory-mapped input port on the 6502 bus.
//
// Synchronises the external pins, detects per-bit edges of a selectable
// polarity, latches them as sticky flags and drives an active-low IRQ.
// All state updates on the falling edge of CLK (PHI0).
//
// Register map (RS):
//   0 PIN   read-only synchronised (or debounced) pin level
//   1 FLAGS read edge flags; write 1 to clear a bit (W1C)
//   2 MASK  read/write; 1 routes that flag onto IRQ
//   3 POL   read/write; 0 = falling edge, 1 = rising edge
//
// Ports:
//   CLK   bus clock, registers update on negedge
//   RST   asynchronous active-low reset
//   EN    active-low chip select
//   RW    1 = read, 0 = write
//   RS    register select
//   DATA  bidirectional CPU data bus, driven only while reading
//   IO    asynchronous external input pins
//   IRQ   active-low interrupt request
//
// Optional feature: define DEBOUNCE_EN to insert a per-bit debounce counter
// between the synchroniser and PIN (DEBOUNCE_CYCLES consecutive edges).
module gpio_input_port #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       EN,
  input  logic       RW,
  input  logic [1:0] RS,
  inout  wire  [7:0] DATA,
  input  logic [7:0] IO,
  output logic       IRQ
);

  // Synchroniser chain; stage 0 samples the raw pins.
  logic [SYNC_STAGES-1:0][7:0] sync_q;
  logic [7:0]                  sync_out;
  logic [7:0]                  pin;

  logic [7:0] prev_q;
  logic [7:0] flags_q, flags_d;
  logic [7:0] mask_q, mask_d;
  logic [7:0] pol_q, pol_d;
  logic [7:0] edge_evt;
  logic [7:0] rdata;
  logic       wr_en;

  always_ff @(negedge CLK or negedge RST) begin
    if (!RST) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], IO};
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef DEBOUNCE_EN
  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [7:0][CntW-1:0] cnt_q, cnt_d;
  logic [7:0]           pin_q, pin_d;

  // A bit's count advances only while the synchronised level disagrees with
  // PIN; any agreement (including a glitch reverting) restarts it.
  always_comb begin
    cnt_d = cnt_q;
    pin_d = pin_q;
    for (int i = 0; i < 8; i++) begin
      if (sync_out[i] != pin_q[i]) begin
        if (cnt_q[i] == CntW'(DEBOUNCE_CYCLES - 1)) begin
          pin_d[i] = sync_out[i];
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CntW'(1);
        end
      end else begin
        cnt_d[i] = '0;
      end
    end
  end

  always_ff @(negedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_q <= '0;
      pin_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      pin_q <= pin_d;
    end
  end

  assign pin = pin_q;
`else
  // DEBOUNCE_CYCLES only matters when the debounce stage is built.
  logic unused_debounce_cycles;
  assign unused_debounce_cycles = ^DEBOUNCE_CYCLES;

  assign pin = sync_out;
`endif

  assign wr_en = ~EN & ~RW;

  // Per-bit selectable edge: rising where POL=1, falling where POL=0.
  assign edge_evt = (pol_q & pin & ~prev_q) | (~pol_q & ~pin & prev_q);

  always_comb begin
    flags_d = flags_q;
    mask_d  = mask_q;
    pol_d   = pol_q;
    if (wr_en) begin
      unique case (RS)
        2'd1:    flags_d = flags_q & ~DATA;
        2'd2:    mask_d  = DATA;
        2'd3:    pol_d   = DATA;
        default: ;
      endcase
    end
    // Applied after the clear so a coincident edge keeps the flag set.
    flags_d = flags_d | edge_evt;
  end

  always_ff @(negedge CLK or negedge RST) begin
    if (!RST) begin
      prev_q  <= '0;
      flags_q <= '0;
      mask_q  <= '0;
      pol_q   <= '0;
    end else begin
      prev_q  <= pin;
      flags_q <= flags_d;
      mask_q  <= mask_d;
      pol_q   <= pol_d;
    end
  end

  assign IRQ = ~|(flags_q & mask_q);

  always_comb begin
    rdata = '0;
    unique case (RS)
      2'd0: rdata = pin;
      2'd1: rdata = flags_q;
      2'd2: rdata = mask_q;
      2'd3: rdata = pol_q;
      default: ;
    endcase
  end

  // Bus is released while in reset so the port never fights the CPU.
  assign DATA = (RST && !EN && RW) ? rdata : 8'hzz;

endmodule

// File: tb/tb_gpio_input_port.sv
module tb_gpio_input_port;

  logic       clk;
  logic       rst;
  logic       en;
  logic       rw;
  logic [1:0] rs;
  logic [7:0] io;
  logic       irq;
  wire  [7:0] data;
  logic [7:0] drv;
  logic       drv_en;

  int n_tests;
  int n_fail;

  assign data = drv_en ? drv : 8'hzz;

  // Weak pull-ups make a released bus read back as 0xFF.
  for (genvar g = 0; g < 8; g++) begin : g_pu
    pullup (data[g]);
  end

  gpio_input_port #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .EN  (en),
    .RW  (rw),
    .RS  (rs),
    .DATA(data),
    .IO  (io),
    .IRQ (irq)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] exp;
  } sb_t;

  sb_t sb[$];

  typedef struct {
    string      name;
    logic [7:0] io;
    bit         wr;
    logic [1:0] wrs;
    logic [7:0] wdata;
    int         waitn;
    logic [1:0] rrs;
    logic [7:0] exp;
    logic       exp_irq;
  } vec_t;

  vec_t vecs[$];

  // Leaves the bench 2 ns after the n-th following falling edge.
  task automatic edges(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  task automatic rd(input logic [1:0] r, output logic [7:0] v);
    en = 1'b0;
    rw = 1'b1;
    rs = r;
    #1;
    v  = data;
    en = 1'b1;
  endtask

  task automatic wr(input logic [1:0] r, input logic [7:0] v);
    en     = 1'b0;
    rw     = 1'b0;
    rs     = r;
    drv    = v;
    drv_en = 1'b1;
    @(negedge clk);
    #2;
    en     = 1'b1;
    rw     = 1'b1;
    drv_en = 1'b0;
  endtask

  task automatic check_reg(input string name, input logic [1:0] r, input logic [7:0] exp);
    logic [7:0] v;
    sb_t        e;
    sb.push_back('{name, exp});
    rd(r, v);
    e = sb.pop_front();
    n_tests++;
    if (v !== e.exp) begin
      n_fail++;
      $display("FAIL %s: read %02h expected %02h", e.name, v, e.exp);
    end
  endtask

  task automatic check_irq(input string name, input logic exp);
    n_tests++;
    if (irq !== exp) begin
      n_fail++;
      $display("FAIL %s: irq %b expected %b", name, irq, exp);
    end
  endtask

  task automatic check_bus(input string name, input logic [7:0] exp);
    n_tests++;
    if (data !== exp) begin
      n_fail++;
      $display("FAIL %s: bus %02h expected %02h", name, data, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b0;
    en      = 1'b1;
    rw      = 1'b1;
    rs      = 2'd0;
    io      = 8'h00;
    drv     = 8'h00;
    drv_en  = 1'b0;

    // name, io, wr, wrs, wdata, wait, rrs, exp, irq
    vecs.push_back('{"mask_wr",     8'hFF, 1'b1, 2'd2, 8'h01, 0, 2'd2, 8'h01, 1'b1});
    vecs.push_back('{"pol_wr",      8'hFF, 1'b1, 2'd3, 8'h00, 0, 2'd3, 8'h00, 1'b1});
    vecs.push_back('{"pin_e1",      8'hFE, 1'b0, 2'd0, 8'h00, 1, 2'd0, 8'hFF, 1'b1});
    vecs.push_back('{"pin_e2",      8'hFE, 1'b0, 2'd0, 8'h00, 1, 2'd0, 8'hFE, 1'b1});
    vecs.push_back('{"flags_e2",    8'hFE, 1'b0, 2'd0, 8'h00, 0, 2'd1, 8'h00, 1'b1});
    vecs.push_back('{"flags_e3",    8'hFE, 1'b0, 2'd0, 8'h00, 1, 2'd1, 8'h01, 1'b0});
    vecs.push_back('{"w1c_bit0",    8'hFE, 1'b1, 2'd1, 8'h01, 0, 2'd1, 8'h00, 1'b1});
    vecs.push_back('{"mask_clr",    8'hFE, 1'b1, 2'd2, 8'h00, 0, 2'd2, 8'h00, 1'b1});
    vecs.push_back('{"masked_fall", 8'h7E, 1'b0, 2'd0, 8'h00, 3, 2'd1, 8'h80, 1'b1});
    vecs.push_back('{"w1c_all",     8'h7E, 1'b1, 2'd1, 8'hFF, 0, 2'd1, 8'h00, 1'b1});
    vecs.push_back('{"pol_80",      8'h7E, 1'b1, 2'd3, 8'h80, 0, 2'd3, 8'h80, 1'b1});
    vecs.push_back('{"pol_no_flag", 8'h7E, 1'b0, 2'd0, 8'h00, 0, 2'd1, 8'h00, 1'b1});
    vecs.push_back('{"rise_b7",     8'hFE, 1'b0, 2'd0, 8'h00, 3, 2'd1, 8'h80, 1'b1});
    vecs.push_back('{"unmask_b7",   8'hFE, 1'b1, 2'd2, 8'h80, 0, 2'd1, 8'h80, 1'b0});

    // Reset state
    #7;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_reg($sformatf("reset_rs%0d", i), 2'(i), 8'h00);
    end
    check_irq("reset_irq", 1'b1);
    #1;
    check_bus("reset_hiz", 8'hFF);

    // Rising pins are ignored while POL is all-falling.
    io = 8'hFF;
    edges(4);
    check_reg("pin_ff", 2'd0, 8'hFF);
    check_reg("rise_ignored", 2'd1, 8'h00);

    foreach (vecs[i]) begin
      io = vecs[i].io;
      if (vecs[i].wr) wr(vecs[i].wrs, vecs[i].wdata);
      if (vecs[i].waitn > 0) edges(vecs[i].waitn);
      check_reg(vecs[i].name, vecs[i].rrs, vecs[i].exp);
      check_irq({vecs[i].name, "_irq"}, vecs[i].exp_irq);
    end

    // Set wins over a coincident W1C.
    wr(2'd1, 8'hFF);
    wr(2'd2, 8'h01);
    wr(2'd3, 8'h00);
    io = 8'hFF;
    edges(3);
    io = 8'hFC;
    edges(3);
    check_reg("flags_03", 2'd1, 8'h03);
    check_irq("flags_03_irq", 1'b0);
    io = 8'hFD;
    edges(3);
    check_reg("flags_hold", 2'd1, 8'h03);
    io = 8'hFC;
    edges(2);
    wr(2'd1, 8'h01);
    check_reg("set_wins", 2'd1, 8'h03);
    wr(2'd1, 8'h02);
    check_reg("w1c_bit1", 2'd1, 8'h01);
    check_irq("w1c_bit1_irq", 1'b0);

    // Asynchronous reset mid-cycle.
    wr(2'd1, 8'hFF);
    wr(2'd2, 8'hFF);
    io = 8'hFF;
    edges(3);
    io = 8'hF0;
    edges(3);
    check_reg("flags_0f", 2'd1, 8'h0F);
    check_irq("flags_0f_irq", 1'b0);
    edges(1);
    rst = 1'b0;
    #1;
    check_irq("async_rst_irq", 1'b1);
    en = 1'b0;
    rw = 1'b1;
    #1;
    check_bus("async_rst_hiz", 8'hFF);
    en  = 1'b1;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_reg($sformatf("async_rst_rs%0d", i), 2'(i), 8'h00);
    end

`ifdef DEBOUNCE_EN
    edges(10);
    check_reg("db_pin_f0", 2'd0, 8'hF0);
    wr(2'd3, 8'h08);
    io = 8'hF8;
    edges(3);
    io = 8'hF0;
    edges(8);
    check_reg("db_short_pin", 2'd0, 8'hF0);
    check_reg("db_short_flags", 2'd1, 8'h00);
    io = 8'hF8;
    edges(5);
    check_reg("db_long_e5", 2'd0, 8'hF0);
    edges(1);
    check_reg("db_long_e6", 2'd0, 8'hF8);
    check_reg("db_flags_e6", 2'd1, 8'h00);
    edges(1);
    check_reg("db_flags_e7", 2'd1, 8'h08);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
